// File: rtl/fmul_pipe.sv
// fmul_pipe: fully pipelined binary32 multiplier with valid/ready handshake.
// Handles IEEE special values, rounds to nearest even, and flushes denormal
// operands and results to zero. One operation per cycle when unstalled.
// Results come back in issue order with exception flags.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   x1, x2                binary32 operands
//   in_tag                opaque tag carried with the operation
//   in_valid / in_ready   input handshake (in_ready combinational from out_ready)
//   y                     binary32 product
//   out_tag               tag of the operation producing y
//   flags                 {nv, ovf, unf}
//   out_valid / out_ready output handshake
module fmul_pipe #(
  parameter int LATENCY = 3,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       flags,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NMID = LATENCY - 2;

  localparam logic [1:0] CLS_NRM  = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  typedef struct packed {
    logic [35:0]      pp_lo;
    logic [35:0]      pp_hi;
    logic [9:0]       exp;
    logic             sgn;
    logic [1:0]       cls;
    logic [TAG_W-1:0] tag;
  } s0_t;

  typedef struct packed {
    logic [47:0]      prod;
    logic [9:0]       exp;
    logic             sgn;
    logic [1:0]       cls;
    logic [TAG_W-1:0] tag;
  } sum_t;

  function automatic logic [1:0] f_class(input logic [31:0] x);
    logic [1:0] c;
    if (x[30:23] == 8'd0)       c = CLS_ZERO;
    else if (x[30:23] == 8'hFF) c = (x[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    else                        c = CLS_NRM;
    return c;
  endfunction

  // Classification, sign, biased exponent sum and the two halves of the
  // 24x24 mantissa product (operand B split into 12-bit halves).
  function automatic s0_t f_stage0(input logic [31:0] a, input logic [31:0] b,
                                   input logic [TAG_W-1:0] t);
    s0_t        s;
    logic [1:0] ca;
    logic [1:0] cb;
    logic [23:0] ma;
    logic [23:0] mb;
    ca = f_class(a);
    cb = f_class(b);
    ma = {1'b1, a[22:0]};
    mb = {1'b1, b[22:0]};
    s.pp_lo = {12'd0, ma} * {24'd0, mb[11:0]};
    s.pp_hi = {12'd0, ma} * {24'd0, mb[23:12]};
    s.exp   = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    s.sgn   = a[31] ^ b[31];
    if (ca == CLS_NAN || cb == CLS_NAN ||
        (ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF))
      s.cls = CLS_NAN;
    else if (ca == CLS_INF || cb == CLS_INF)
      s.cls = CLS_INF;
    else if (ca == CLS_ZERO || cb == CLS_ZERO)
      s.cls = CLS_ZERO;
    else
      s.cls = CLS_NRM;
    s.tag = t;
    return s;
  endfunction

  function automatic sum_t f_sum(input s0_t s);
    sum_t r;
    r.prod = {12'd0, s.pp_lo} + {s.pp_hi, 12'd0};
    r.exp  = s.exp;
    r.sgn  = s.sgn;
    r.cls  = s.cls;
    r.tag  = s.tag;
    return r;
  endfunction

  // Normalise, round to nearest even, saturate exponent; returns {y, flags}.
  function automatic logic [34:0] f_round(input sum_t m);
    logic               n;
    logic [22:0]        frac;
    logic               g;
    logic               st;
    logic [23:0]        fr;
    logic               c;
    logic signed [9:0]  e;
    logic [31:0]        r_y;
    logic [2:0]         r_fl;
    n = m.prod[47];
    if (n) begin
      frac = m.prod[46:24];
      g    = m.prod[23];
      st   = |m.prod[22:0];
    end else begin
      frac = m.prod[45:23];
      g    = m.prod[22];
      st   = |m.prod[21:0];
    end
    fr = {1'b0, frac} + {23'd0, g & (st | frac[0])};
    c  = fr[23];
    e  = $signed(m.exp) + $signed({9'd0, n}) + $signed({9'd0, c});
    r_y  = '0;
    r_fl = '0;
    case (m.cls)
      CLS_NAN: begin
        r_y  = 32'h7FC0_0000;
        r_fl = 3'b100;
      end
      CLS_INF:  r_y = {m.sgn, 8'hFF, 23'd0};
      CLS_ZERO: r_y = {m.sgn, 31'd0};
      default: begin
        if (e >= 10'sd255) begin
          r_y  = {m.sgn, 8'hFF, 23'd0};
          r_fl = 3'b010;
        end else if (e <= 10'sd0) begin
          r_y  = {m.sgn, 31'd0};
          r_fl = 3'b001;
        end else begin
          r_y = {m.sgn, e[7:0], fr[22:0]};
        end
      end
    endcase
    return {r_y, r_fl};
  endfunction

  logic             w_en;
  logic             r_vld_p0;
  s0_t              r_s0_p0;
  sum_t             w_sum_p0;
  sum_t             w_fin_src;
  logic             w_fin_vld;
  logic             r_vld_out;
  logic [31:0]      r_y;
  logic [TAG_W-1:0] r_tag;
  logic [2:0]       r_flags;

  assign w_en     = ~r_vld_out | out_ready;
  assign in_ready = w_en;

  // ---- stage 0: classification and partial products ----
  always_ff @(posedge clk) begin
    if (rst)       r_vld_p0 <= 1'b0;
    else if (w_en) r_vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (w_en) r_s0_p0 <= f_stage0(x1, x2, in_tag);
  end

  assign w_sum_p0 = f_sum(r_s0_p0);

  // ---- stages 1..LATENCY-2: partial-product sum, then delay ----
  generate
    if (NMID == 0) begin : g_nomid
      assign w_fin_src = w_sum_p0;
      assign w_fin_vld = r_vld_p0;
    end else begin : g_mid
      sum_t            r_mid_p1 [NMID];
      logic [NMID-1:0] r_vld_p1;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld_p1 <= '0;
        end else if (w_en) begin
          r_vld_p1[0] <= r_vld_p0;
          for (int i = 1; i < NMID; i++) r_vld_p1[i] <= r_vld_p1[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (w_en) begin
          r_mid_p1[0] <= w_sum_p0;
          for (int i = 1; i < NMID; i++) r_mid_p1[i] <= r_mid_p1[i-1];
        end
      end

      assign w_fin_src = r_mid_p1[NMID-1];
      assign w_fin_vld = r_vld_p1[NMID-1];
    end
  endgenerate

  // ---- last stage: rounded, packed result ----
  // Output payload is cleared on reset so it reads zero until the first result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_out <= 1'b0;
      r_y       <= '0;
      r_tag     <= '0;
      r_flags   <= '0;
    end else if (w_en) begin
      r_vld_out        <= w_fin_vld;
      {r_y, r_flags}   <= f_round(w_fin_src);
      r_tag            <= w_fin_src.tag;
    end
  end

  assign out_valid = r_vld_out;
  assign y         = r_y;
  assign out_tag   = r_tag;
  assign flags     = r_flags;

endmodule

// File: tb/tb_fmul_pipe.sv
module tb_fmul_pipe;
  localparam int LAT = 3;
  localparam int TW  = 4;
  localparam int NV  = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   x1, x2;
  logic [TW-1:0] in_tag;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   y;
  logic [TW-1:0] out_tag;
  logic [2:0]    flags;
  logic          out_valid;
  logic          out_ready;

  always #5 clk = ~clk;

  fmul_pipe #(.LATENCY(LAT), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .x1(x1), .x2(x2), .in_tag(in_tag),
    .in_valid(in_valid), .in_ready(in_ready), .y(y), .out_tag(out_tag),
    .flags(flags), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Directed vectors with hand-computed products; flags are {nv, ovf, unf}.
  logic [31:0] va [NV] = '{32'h3FC00000, 32'h3F800001, 32'h3F800003, 32'h7F000000,
                           32'h00800000, 32'h80800000, 32'h7F800000, 32'hFF800000,
                           32'h7FC00001, 32'h40400000, 32'h00000000, 32'h3FFFFFFF};
  logic [31:0] vb [NV] = '{32'h40000000, 32'h3FC00000, 32'h3FC00000, 32'h40000000,
                           32'h3F000000, 32'h3F000000, 32'h00000000, 32'h40000000,
                           32'h3F800000, 32'h40400000, 32'hC0000000, 32'h3FFFFFFF};
  logic [31:0] vy [NV] = '{32'h40400000, 32'h3FC00002, 32'h3FC00004, 32'h7F800000,
                           32'h00000000, 32'h80000000, 32'h7FC00000, 32'hFF800000,
                           32'h7FC00000, 32'h41100000, 32'h80000000, 32'h407FFFFE};
  logic [2:0]  vf [NV] = '{3'b000, 3'b000, 3'b000, 3'b010,
                           3'b001, 3'b001, 3'b100, 3'b000,
                           3'b100, 3'b000, 3'b000, 3'b000};

  typedef struct packed {
    logic [31:0]   y;
    logic [2:0]    fl;
    logic [TW-1:0] tag;
    logic [31:0]   cyc;
    logic          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] drv_y  = '0;
  logic [2:0]  drv_fl = '0;
  logic        done   = 1'b0;
  int          n_cmp  = 0;
  int          n_bad  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Monitor / scoreboard: samples on the falling edge.
  initial begin : monitor
    exp_t          e;
    logic [31:0]   cyc;
    logic [31:0]   appear;
    logic          was_rst;
    logic          prev_stall;
    logic [31:0]   prev_y;
    logic [TW-1:0] prev_tag;
    logic [2:0]    prev_fl;
    cyc = 0; appear = 0; was_rst = 0; prev_stall = 0;
    prev_y = 0; prev_tag = 0; prev_fl = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        n_cmp++; n_bad++;
        $display("FAIL watchdog: cycle %0d reached, required earlier completion", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
      if (rst) begin
        sb.delete();
        was_rst = 1; prev_stall = 0;
      end else begin
        if (was_rst) begin
          chk("rst_out_valid", 32'(out_valid), 32'd0);
          chk("rst_in_ready",  32'(in_ready),  32'd1);
          chk("rst_y",         y,              32'd0);
          chk("rst_out_tag",   32'(out_tag),   32'd0);
          chk("rst_flags",     32'(flags),     32'd0);
        end
        was_rst = 0;
        if (prev_stall) begin
          chk("stall_out_valid", 32'(out_valid), 32'd1);
          chk("stall_y_hold",    y,              prev_y);
          chk("stall_tag_hold",  32'(out_tag),   32'(prev_tag));
          chk("stall_flag_hold", 32'(flags),     32'(prev_fl));
        end
        if (out_valid && !prev_stall) appear = cyc;
        if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_output: got tag %h y %h, required no output", out_tag, y);
          end else begin
            e = sb.pop_front();
            chk("y",       y,            e.y);
            chk("out_tag", 32'(out_tag), 32'(e.tag));
            chk("flags",   32'(flags),   32'(e.fl));
            if (e.lat) chk("latency", appear - e.cyc, 32'(LAT));
          end
        end
        if (in_valid && in_ready) begin
          e.y   = drv_y;
          e.fl  = drv_fl;
          e.tag = in_tag;
          e.cyc = cyc;
          e.lat = (sb.size() == 0);
          sb.push_back(e);
        end
        prev_stall = out_valid && !out_ready;
        prev_y     = y;
        prev_tag   = out_tag;
        prev_fl    = flags;
      end
      if (done) begin
        chk("drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t,
                       input logic [31:0] ey, input logic [2:0] ef);
    int g;
    g = 0;
    x1 = a; x2 = b; in_tag = t; drv_y = ey; drv_fl = ef;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x1 = '0; x2 = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed singles, back to back with out_ready high.
    for (int i = 0; i < NV; i++) issue(va[i], vb[i], TW'(i + 5), vy[i], vf[i]);
    wait_drain();

    // Backpressure: 8 ops, tags 0..7, consumer stalls 5 cycles at first result.
    fork
      begin
        for (int i = 0; i < 8; i++) issue(va[i], vb[i], TW'(i), vy[i], vf[i]);
      end
      begin
        int g;
        g = 0;
        @(posedge clk);
        #1;
        while (!out_valid && g < 50) begin
          @(posedge clk);
          #1;
          g++;
        end
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset mid-stream with three ops in flight.
    for (int i = 0; i < 3; i++) issue(va[i + 9], vb[i + 9], TW'(i + 10), vy[i + 9], vf[i + 9]);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    issue(va[0], vb[0], TW'(9), vy[0], vf[0]);
    wait_drain();
    repeat (3) @(posedge clk);
    #1 done = 1'b1;
  end

endmodule

// File: doc/fmul_pipe.md
# fmul_pipe

Fully pipelined single-precision floating-point multiplier with streaming valid/ready handshake, configurable latency, tag passthrough, round-to-nearest-even and IEEE-style special-value handling. It sits in the FPU next to the existing multi-cycle multiplier, accepts one operation per cycle when unstalled, and returns results in issue order with exception flags. Denormal operands and results are flushed to zero.

## Interface

Parameters:
- LATENCY, default 3: cycles from input acceptance to `out_valid`; legal range 2..4.
- TAG_W, default 4: width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- x1  in  32  operand A, IEEE-754 binary32.
- x2  in  32  operand B, IEEE-754 binary32.
- in_tag  in  TAG_W  tag captured with the operands.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept this cycle.
- y  out  32  product.
- out_tag  out  TAG_W  tag of the operation producing `y`.
- flags  out  3  {nv, ovf, unf}, valid with `out_valid`.
- out_valid  out  1  `y`, `out_tag` and `flags` valid.
- out_ready  in  1  consumer accepts this cycle.

## Operation

- Pipeline is LATENCY stages, each holding a valid bit plus payload. Global enable `en = ~out_valid | out_ready`. When `en` is high, all stages shift by one and stage 0 loads `in_valid` and the inputs. When `en` is low, all stages hold.
- `in_ready = en`. This is a combinational path from `out_ready`, which is intentional. A transfer occurs when `in_valid & in_ready`. Bubbles are not collapsed.
- Operand classes by exponent field: 0 is zero (mantissa ignored, denormal flushed); 255 with mantissa 0 is inf; 255 with mantissa nonzero is NaN; anything else is normal with hidden 1.
- Sign: `s = x1[31] ^ x2[31]` for every non-NaN result.
- Special cases, evaluated in priority order:
  1. Either operand NaN, or inf×zero: y=0x7FC00000, nv=1.
  2. Either operand inf: y={s, 0xFF, 0}.
  3. Either operand zero: y={s, 31'b0}.
- Normal path:
  - Mantissa product: P = {1,m1}·{1,m2}, 48 bits.
  - n = P[47].
  - If n: frac=P[46:24], guard=P[23], sticky=|P[22:0].
  - Else: frac=P[45:23], guard=P[22], sticky=|P[21:0].
  - Round to nearest even: round up iff guard & (sticky | frac[0]).
  - If frac overflows on rounding: frac=0, c=1; else c=0.
  - Exponent: E = e1 + e2 − 127 + n + c, evaluated as 10-bit signed.
  - E ≥ 255: y={s, 0xFF, 0}, ovf=1.
  - E ≤ 0: y={s, 31'b0}, unf=1.
  - Otherwise: y={s, E[7:0], frac}.
- Flags not named in a case are 0. `out_tag` equals the `in_tag` of the same operation.
- Stage split (mandatory boundaries):
  - Stage 0 registers the classification and partial products (split of the 24×24 multiply).
  - The last stage registers the final packed result.
  - Extra stages for LATENCY = 4 are inserted between partial-product sum and rounding.
  - For LATENCY = 2, sum and round share the last stage.

## Timing

- Reset: all stage valid bits 0, so out_valid=0 and in_ready=1 in the cycle after reset. y, out_tag and flags read 0 after reset; they are don't-care while out_valid=0.
- Latency: an operation accepted at edge k appears with out_valid=1 after edge k+LATENCY−1 and remains until accepted.
- Throughput: 1 op/cycle with out_ready held high.
- Stall: while out_valid=1 and out_ready=0, every stage, y, out_tag and flags are stable and in_ready=0.
- Simultaneous acceptance on both ends in one cycle: both transfers occur.
- Reset asserted mid-operation discards all in-flight operations. No output transfer occurs in the reset cycle.

## Test plan

- 0x3FC00000 × 0x40000000, tag 5, out_ready=1 → after LATENCY cycles: y=0x40400000, out_tag=5, flags=000.
- RNE ties:
  - 0x3F800001 × 0x3FC00000 → y=0x3FC00002 (tie, round up to even).
  - 0x3F800003 × 0x3FC00000 → y=0x3FC00004 (tie, round down to even).
- Range limits:
  - 0x7F000000 × 0x40000000 → y=0x7F800000, ovf=1.
  - 0x00800000 × 0x3F000000 → y=0x00000000, unf=1.
  - 0x80800000 × 0x3F000000 → y=0x80000000, unf=1.
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, nv=1.
  - 0xFF800000 × 0x40000000 → 0xFF800000, flags=000.
  - 0x7FC00001 × 1.0 → 0x7FC00000, nv=1.
- Backpressure: issue 8 back-to-back ops with tags 0..7, drive out_ready low for 5 cycles after the first result → in_ready=0 while stalled, held output stable, all 8 results delivered in tag order with none lost or duplicated.
- Reset mid-stream: 3 ops in flight, assert rst one cycle → out_valid=0 and in_ready=1 afterward, no stale results emerge, next op completes normally after LATENCY cycles.
